fetch_entry_queue: RTL and testbench

Frontend-side producer of the fetch→decode handshake. It accepts 32-bit instruction-cache fetch blocks and realigns them into individual RVI/RVC instructions, including instructions that straddle two blocks. It buffers these instructions in a small FIFO and presents one fetch entry per cycle to the decode stage over a valid/ready handshake. It sits between the I$ response path and the decode stage, replacing a direct fetch-to-decode connection.

---
 rtl/fetch_entry_queue.sv | 142 ++++++++++++++
 tb/tb_fetch_entry_queue.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_entry_queue.sv
// fetch_entry_queue: realigns 32-bit I$ fetch blocks into RVI/RVC instructions
// (including ones straddling two blocks) and queues them toward decode.
module fetch_entry_queue #(
  parameter int VLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            fetch_valid_i,
  output logic            fetch_ready_o,
  input  logic [31:0]     fetch_data_i,
  input  logic [VLEN-1:0] fetch_addr_i,
  input  logic            fetch_ex_valid_i,
  output logic            fetch_entry_valid_o,
  input  logic            fetch_entry_ready_i,
  output logic [31:0]     instr_o,
  output logic [VLEN-1:0] addr_o,
  output logic            ex_valid_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0]     instr;
    logic [VLEN-1:0] addr;
    logic            ex;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wr, r_rd;
  logic [CW-1:0]   r_count;
  logic            r_has_half;
  logic [15:0]     r_half;
  logic [VLEN-1:0] r_half_addr;

  logic [15:0]     w_lo, w_hi;
  logic            w_accept, w_pop, w_use_half, w_do_up, w_hold;
  logic            w_first_vld, w_up_vld;
  entry_t          w_first, w_up, w_slot0, w_head;
  logic [1:0]      w_npush;
  logic [VLEN-1:0] w_up_addr;
  logic [PW-1:0]   w_wr1;

  assign w_lo     = fetch_data_i[15:0];
  assign w_hi     = fetch_data_i[31:16];
  // Same-cycle pops are not credited, so readiness depends on count alone.
  assign fetch_ready_o       = (r_count <= CW'(DEPTH - 2)) && !flush_i;
  assign fetch_entry_valid_o = (r_count != '0);
  assign w_accept = fetch_valid_i && fetch_ready_o;
  assign w_pop    = fetch_entry_valid_o && fetch_entry_ready_i && !flush_i;
  assign w_head   = r_mem[r_rd];
  assign instr_o  = w_head.instr;
  assign addr_o   = w_head.addr;
  assign ex_valid_o = w_head.ex;
  assign w_wr1    = r_wr + PW'(1);

  // Realign the accepted block into up to two entries, in address order.
  always_comb begin
    w_first     = '0;
    w_first_vld = 1'b0;
    w_up        = '0;
    w_up_vld    = 1'b0;
    w_hold      = 1'b0;
    w_do_up     = 1'b0;
    w_use_half  = r_has_half && (fetch_addr_i == r_half_addr + VLEN'(2)) && !fetch_addr_i[1];
    w_up_addr   = fetch_addr_i[1] ? fetch_addr_i : fetch_addr_i + VLEN'(2);
    if (w_accept) begin
      if (fetch_ex_valid_i) begin
        w_first_vld = 1'b1;
        w_first.addr = fetch_addr_i;
        w_first.ex   = 1'b1;
      end else begin
        if (w_use_half) begin
          w_first_vld   = 1'b1;
          w_first.instr = {w_lo, r_half};
          w_first.addr  = r_half_addr;
          w_do_up       = 1'b1;
        end else if (!fetch_addr_i[1]) begin
          w_first_vld  = 1'b1;
          w_first.addr = fetch_addr_i;
          if (w_lo[1:0] != 2'b11) begin
            w_first.instr = {16'h0, w_lo};
            w_do_up       = 1'b1;
          end else begin
            w_first.instr = fetch_data_i;
          end
        end else begin
          w_do_up = 1'b1;
        end
        if (w_do_up) begin
          if (w_hi[1:0] != 2'b11) begin
            w_up_vld   = 1'b1;
            w_up.instr = {16'h0, w_hi};
            w_up.addr  = w_up_addr;
          end else begin
            w_hold = 1'b1;
          end
        end
      end
    end
    w_slot0 = w_first_vld ? w_first : w_up;
    w_npush = {1'b0, w_first_vld} + {1'b0, w_up_vld};
  end

  // Held low half of a straddling RVI; any non-matching or faulting block drops it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_has_half  <= 1'b0;
      r_half      <= '0;
      r_half_addr <= '0;
    end else if (flush_i) begin
      r_has_half <= 1'b0;
    end else if (w_accept) begin
      r_has_half <= w_hold;
      if (w_hold) begin
        r_half      <= w_hi;
        r_half_addr <= w_up_addr;
      end
    end
  end

  // Circular buffer: up to two writes and one read per cycle; flush wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_npush != 2'd0) r_mem[r_wr]  <= w_slot0;
      if (w_npush == 2'd2) r_mem[w_wr1] <= w_up;
      r_wr    <= r_wr + PW'(w_npush);
      r_rd    <= r_rd + PW'(w_pop);
      r_count <= r_count + CW'(w_npush) - CW'(w_pop);
    end
  end
endmodule

// File: tb/tb_fetch_entry_queue.sv
// Scoreboard bench for fetch_entry_queue: tests queue expected entries, a
// monitor pops and compares them whenever decode takes the head.
module tb_fetch_entry_queue;
  logic        clk = 1'b0;
  logic        rst_ni, flush_i, fetch_valid_i, fetch_ready_o, fetch_ex_valid_i;
  logic [31:0] fetch_data_i, instr_o;
  logic [63:0] fetch_addr_i, addr_o;
  logic        fetch_entry_valid_o, fetch_entry_ready_i, ex_valid_o;

  typedef struct {
    logic [31:0] i;
    logic [63:0] a;
    logic        e;
  } exp_t;
  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  fetch_entry_queue #(.VLEN(64), .DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
    .fetch_data_i(fetch_data_i), .fetch_addr_i(fetch_addr_i),
    .fetch_ex_valid_i(fetch_ex_valid_i),
    .fetch_entry_valid_o(fetch_entry_valid_o), .fetch_entry_ready_i(fetch_entry_ready_i),
    .instr_o(instr_o), .addr_o(addr_o), .ex_valid_o(ex_valid_o));

  always #5 clk = ~clk;

  // Scoreboard consumer: every handshake pops one expected entry.
  always @(negedge clk) begin
    if (rst_ni && !flush_i && fetch_entry_valid_o && fetch_entry_ready_i) begin
      exp_t x;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL pop_unexpected got instr=%h addr=%h ex=%b, expected no entry", instr_o, addr_o, ex_valid_o);
      end else begin
        x = sb.pop_front();
        if ({instr_o, addr_o, ex_valid_o} !== {x.i, x.a, x.e}) begin
          miscompares++;
          $display("FAIL pop_data got instr=%h addr=%h ex=%b, expected instr=%h addr=%h ex=%b",
                   instr_o, addr_o, ex_valid_o, x.i, x.a, x.e);
        end
      end
    end
  end

  function automatic void expect_entry(input logic [31:0] i, input logic [63:0] a, input logic e);
    exp_t x;
    x.i = i; x.a = a; x.e = e;
    sb.push_back(x);
  endfunction

  // Drive one block and hold it until accepted (bounded).
  task automatic send(input logic [63:0] a, input logic [31:0] d, input logic ex);
    int n = 0;
    @(posedge clk); #1;
    fetch_valid_i = 1'b1; fetch_addr_i = a; fetch_data_i = d; fetch_ex_valid_i = ex;
    @(negedge clk);
    while (!fetch_ready_o && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      miscompares++;
      $display("FAIL send_timeout addr=%h never accepted", a);
    end
    @(posedge clk); #1;
    fetch_valid_i = 1'b0; fetch_ex_valid_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    fetch_entry_ready_i = 1'b1;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    vectors++;
    if (sb.size() != 0 || fetch_entry_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_drain left=%0d valid=%b, expected 0 and 0", name, sb.size(), fetch_entry_valid_o);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({fetch_entry_valid_o, fetch_ready_o, instr_o, addr_o, ex_valid_o} !== {1'b0, 1'b1, 32'h0, 64'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state got v=%b rdy=%b instr=%h addr=%h ex=%b, expected 0 1 0 0 0",
               fetch_entry_valid_o, fetch_ready_o, instr_o, addr_o, ex_valid_o);
    end
  endtask

  task automatic test_aligned_rvi();
    fetch_entry_ready_i = 1'b1;
    expect_entry(32'h00000013, 64'h80000000, 1'b0);
    send(64'h80000000, 32'h00000013, 1'b0);
    @(negedge clk);
    vectors++;
    if (fetch_entry_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rvi_latency valid=%b, expected 1", fetch_entry_valid_o);
    end
    drain("rvi");
  endtask

  task automatic test_dual_rvc();
    fetch_entry_ready_i = 1'b1;
    expect_entry(32'h00004501, 64'h1000, 1'b0);
    expect_entry(32'h00004501, 64'h1002, 1'b0);
    send(64'h1000, 32'h45014501, 1'b0);
    @(negedge clk);
    vectors++;
    if (addr_o !== 64'h1000 || fetch_entry_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rvc_first addr=%h v=%b, expected 1000 1", addr_o, fetch_entry_valid_o);
    end
    @(negedge clk);
    vectors++;
    if (addr_o !== 64'h1002 || fetch_entry_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rvc_second addr=%h v=%b, expected 1002 1", addr_o, fetch_entry_valid_o);
    end
    drain("rvc");
  endtask

  task automatic test_straddle();
    fetch_entry_ready_i = 1'b1;
    expect_entry(32'h00004501, 64'h2000, 1'b0);
    expect_entry(32'h00000013, 64'h2002, 1'b0);
    expect_entry(32'h00004501, 64'h2006, 1'b0);
    send(64'h2000, 32'h00134501, 1'b0);
    send(64'h2004, 32'h45010000, 1'b0);
    @(negedge clk);
    vectors++;
    if (addr_o !== 64'h2002 || instr_o !== 32'h00000013) begin
      miscompares++;
      $display("FAIL straddle_join instr=%h addr=%h, expected 00000013 2002", instr_o, addr_o);
    end
    drain("straddle");
  endtask

  task automatic test_backpressure();
    fetch_entry_ready_i = 1'b0;
    expect_entry(32'h00004501, 64'h1000, 1'b0);
    expect_entry(32'h00004501, 64'h1002, 1'b0);
    expect_entry(32'h00004501, 64'h1004, 1'b0);
    expect_entry(32'h00004501, 64'h1006, 1'b0);
    send(64'h1000, 32'h45014501, 1'b0);
    send(64'h1004, 32'h45014501, 1'b0);
    @(negedge clk);
    vectors++;
    if (fetch_ready_o !== 1'b0 || fetch_entry_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_full rdy=%b v=%b, expected 0 1", fetch_ready_o, fetch_entry_valid_o);
    end
    @(posedge clk); #1 fetch_entry_ready_i = 1'b1;
    @(posedge clk); #1 fetch_entry_ready_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (fetch_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_one_free rdy=%b, expected 0", fetch_ready_o);
    end
    @(posedge clk); #1 fetch_entry_ready_i = 1'b1;
    @(posedge clk); #1 fetch_entry_ready_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (fetch_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_two_free rdy=%b, expected 1", fetch_ready_o);
    end
    drain("bp");
  endtask

  task automatic test_flush();
    fetch_entry_ready_i = 1'b0;
    send(64'h5000, 32'h45014501, 1'b0);
    send(64'h5004, 32'h00134501, 1'b0);
    @(posedge clk); #1;
    flush_i = 1'b1; fetch_valid_i = 1'b1; fetch_addr_i = 64'h5008; fetch_data_i = 32'h00004501;
    @(negedge clk);
    vectors++;
    if (fetch_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ready rdy=%b, expected 0", fetch_ready_o);
    end
    @(posedge clk); #1;
    flush_i = 1'b0; fetch_valid_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (fetch_entry_valid_o !== 1'b0 || fetch_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_empty v=%b rdy=%b, expected 0 1", fetch_entry_valid_o, fetch_ready_o);
    end
    fetch_entry_ready_i = 1'b1;
    // With the half discarded, this block splits into two RVC entries.
    expect_entry(32'h00004501, 64'h5008, 1'b0);
    expect_entry(32'h00000000, 64'h500A, 1'b0);
    send(64'h5008, 32'h00004501, 1'b0);
    expect_entry(32'h00004501, 64'h3002, 1'b0);
    send(64'h3002, 32'h4501BEEF, 1'b0);
    drain("flush");
  endtask

  task automatic test_exception();
    fetch_entry_ready_i = 1'b1;
    expect_entry(32'h00004501, 64'h3FFC, 1'b0);
    send(64'h3FFC, 32'h00134501, 1'b0);
    expect_entry(32'h00000000, 64'h4000, 1'b1);
    send(64'h4000, 32'h12345678, 1'b1);
    @(negedge clk);
    vectors++;
    if (ex_valid_o !== 1'b1 || instr_o !== 32'h0) begin
      miscompares++;
      $display("FAIL ex_entry ex=%b instr=%h, expected 1 00000000", ex_valid_o, instr_o);
    end
    // Half must be gone: this block would otherwise join it at 0x3FFE.
    expect_entry(32'h00004501, 64'h4000, 1'b0);
    expect_entry(32'h00000000, 64'h4002, 1'b0);
    send(64'h4000, 32'h00004501, 1'b0);
    drain("ex");
  endtask

  task automatic test_back_to_back();
    bit done = 1'b0;
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          logic [31:0] d;
          d = $urandom() | 32'h3;
          expect_entry(d, 64'h9000 + 64'(4 * k), 1'b0);
          send(64'h9000 + 64'(4 * k), d, 1'b0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1 fetch_entry_ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    drain("b2b");
  endtask

  task automatic test_reset_mid();
    fetch_entry_ready_i = 1'b0;
    send(64'h6000, 32'h45014501, 1'b0);
    @(posedge clk); #3;
    rst_ni = 1'b0;
    #1;
    vectors++;
    if (fetch_entry_valid_o !== 1'b0 || fetch_ready_o !== 1'b1 || addr_o !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_mid v=%b rdy=%b addr=%h, expected 0 1 0", fetch_entry_valid_o, fetch_ready_o, addr_o);
    end
    @(posedge clk); #1 rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; fetch_valid_i = 1'b0; fetch_data_i = '0;
    fetch_addr_i = '0; fetch_ex_valid_i = 1'b0; fetch_entry_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    @(posedge clk); #1 rst_ni = 1'b1;
    test_aligned_rvi();
    test_dual_rvc();
    test_straddle();
    test_backpressure();
    test_flush();
    test_exception();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
